// File: rtl/pipelined_shifter.sv
// Two-stage pipelined barrel shifter with ARM operand-2 semantics (LSL/LSR/ASR/ROR/RRX).
// Latency: 2 cycles from accept to out_valid; 1 op/cycle sustained.
// Backpressure: in_ready is combinational from out_ready (no skid); outputs hold while stalled.
module pipelined_shifter #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [2:0]       in_op,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int LW = $clog2(WIDTH);

  localparam logic [2:0] OP_LSL = 3'd0;
  localparam logic [2:0] OP_LSR = 3'd1;
  localparam logic [2:0] OP_ASR = 3'd2;
  localparam logic [2:0] OP_ROR = 3'd3;
  localparam logic [2:0] OP_RRX = 3'd4;

  // Stage-1 state: operands plus pre-decoded amount flags
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic             s1_cin_q, s1_cin_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s1_zero_q, s1_zero_d;
  logic             s1_eq_q, s1_eq_d;
  logic             s1_gt_q, s1_gt_d;
  logic [LW-1:0]    s1_rot_q, s1_rot_d;

  // Stage-2 state: the registered output port values
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic             out_cout_q, out_cout_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_illegal_q, out_illegal_d;

  logic s2_adv, s1_adv, accept;

  // Stage-2 combinational result
  logic [WIDTH-1:0] res_c, ror_c;
  logic             cout_c, ill_c, big_c;
  logic [LW-1:0]    sh_c, sh_m1_c, neg_c;

  // Handshake: a stage moves when the stage downstream of it can take its contents
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = s2_adv || !s1_valid_q;
    in_ready = s1_adv && !flush;
    accept   = in_valid && in_ready;
  end

  // Result/carry from stage-1 flags; native shifts only ever see amounts below WIDTH
  always_comb begin
    res_c   = s1_a_q;
    cout_c  = s1_cin_q;
    ill_c   = 1'b0;
    sh_c    = s1_rot_q;
    sh_m1_c = s1_rot_q - LW'(1);
    neg_c   = LW'(0) - s1_rot_q;
    big_c   = s1_eq_q || s1_gt_q;
    ror_c   = (s1_a_q >> sh_c) | (s1_a_q << neg_c);
    case (s1_op_q)
      OP_LSL: begin
        if (!s1_zero_q) begin
          if (big_c) begin
            res_c  = '0;
            cout_c = s1_eq_q ? s1_a_q[0] : 1'b0;
          end else begin
            res_c  = s1_a_q << sh_c;
            cout_c = s1_a_q[neg_c];
          end
        end
      end
      OP_LSR: begin
        if (!s1_zero_q) begin
          if (big_c) begin
            res_c  = '0;
            cout_c = s1_eq_q ? s1_a_q[WIDTH-1] : 1'b0;
          end else begin
            res_c  = s1_a_q >> sh_c;
            cout_c = s1_a_q[sh_m1_c];
          end
        end
      end
      OP_ASR: begin
        if (!s1_zero_q) begin
          if (big_c) begin
            res_c  = {WIDTH{s1_a_q[WIDTH-1]}};
            cout_c = s1_a_q[WIDTH-1];
          end else begin
            res_c  = $signed(s1_a_q) >>> sh_c;
            cout_c = s1_a_q[sh_m1_c];
          end
        end
      end
      OP_ROR: begin
        // rot==0 with nonzero amount falls out as res=a, cout=a[W-1]
        if (!s1_zero_q) begin
          res_c  = ror_c;
          cout_c = ror_c[WIDTH-1];
        end
      end
      OP_RRX: begin
        res_c  = {s1_cin_q, s1_a_q[WIDTH-1:1]};
        cout_c = s1_a_q[0];
      end
      default: ill_c = 1'b1;
    endcase
  end

  // Next-state for both stages; flush overrides accept and output transfer
  always_comb begin
    s1_valid_d    = flush ? 1'b0 : (s1_adv ? accept : s1_valid_q);
    s1_a_d        = s1_a_q;
    s1_op_d       = s1_op_q;
    s1_cin_d      = s1_cin_q;
    s1_tag_d      = s1_tag_q;
    s1_zero_d     = s1_zero_q;
    s1_eq_d       = s1_eq_q;
    s1_gt_d       = s1_gt_q;
    s1_rot_d      = s1_rot_q;
    if (accept) begin
      s1_a_d    = in_a;
      s1_op_d   = in_op;
      s1_cin_d  = in_cin;
      s1_tag_d  = in_tag;
      s1_zero_d = (in_amt == '0);
      s1_eq_d   = (in_amt == AMT_W'(WIDTH));
      s1_gt_d   = (in_amt > AMT_W'(WIDTH));
      s1_rot_d  = in_amt[LW-1:0];
    end
    s2_valid_d    = flush ? 1'b0 : (s2_adv ? s1_valid_q : s2_valid_q);
    out_result_d  = out_result_q;
    out_cout_d    = out_cout_q;
    out_tag_d     = out_tag_q;
    out_illegal_d = out_illegal_q;
    if (s2_adv && s1_valid_q && !flush) begin
      out_result_d  = res_c;
      out_cout_d    = cout_c;
      out_tag_d     = s1_tag_q;
      out_illegal_d = ill_c;
    end
  end

  // Pipeline registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_a_q        <= '0;
      s1_op_q       <= '0;
      s1_cin_q      <= 1'b0;
      s1_tag_q      <= '0;
      s1_zero_q     <= 1'b0;
      s1_eq_q       <= 1'b0;
      s1_gt_q       <= 1'b0;
      s1_rot_q      <= '0;
      s2_valid_q    <= 1'b0;
      out_result_q  <= '0;
      out_cout_q    <= 1'b0;
      out_tag_q     <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_a_q        <= s1_a_d;
      s1_op_q       <= s1_op_d;
      s1_cin_q      <= s1_cin_d;
      s1_tag_q      <= s1_tag_d;
      s1_zero_q     <= s1_zero_d;
      s1_eq_q       <= s1_eq_d;
      s1_gt_q       <= s1_gt_d;
      s1_rot_q      <= s1_rot_d;
      s2_valid_q    <= s2_valid_d;
      out_result_q  <= out_result_d;
      out_cout_q    <= out_cout_d;
      out_tag_q     <= out_tag_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_result  = out_result_q;
  assign out_cout    = out_cout_q;
  assign out_tag     = out_tag_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter: directed spec cases, stall/flush/reset, randomized scoreboard.
// Latency checked at 2 cycles for directed ops.
// Random phase toggles in_valid/out_ready freely and checks hold-stability under stall.
module tb_pipelined_shifter;

  localparam int W  = 32;
  localparam int AW = 8;
  localparam int TW = 4;

  logic          clk, rst_n, flush;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_a;
  logic [2:0]    in_op;
  logic [AW-1:0] in_amt;
  logic          in_cin;
  logic [TW-1:0] in_tag;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_result;
  logic          out_cout;
  logic [TW-1:0] out_tag;
  logic          out_illegal;

  pipelined_shifter #(.WIDTH(W), .AMT_W(AW), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_op(in_op),
    .in_amt(in_amt), .in_cin(in_cin), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_cout(out_cout), .out_tag(out_tag), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: each result bit defined from the shift rules directly
  function automatic logic [W:0] ref_shift(input logic [W-1:0] a, input int op, input int n, input logic cin);
    logic [W-1:0] r;
    logic c;
    r = a;
    c = cin;
    case (op)
      0: if (n != 0) begin
        for (int i = 0; i < W; i++) r[i] = (i - n >= 0) ? a[i - n] : 1'b0;
        c = (n <= W) ? a[W - n] : 1'b0;
      end
      1: if (n != 0) begin
        for (int i = 0; i < W; i++) r[i] = (i + n < W) ? a[i + n] : 1'b0;
        c = (n <= W) ? a[n - 1] : 1'b0;
      end
      2: if (n != 0) begin
        for (int i = 0; i < W; i++) r[i] = a[(i + n < W) ? i + n : W - 1];
        c = a[(n - 1 < W) ? n - 1 : W - 1];
      end
      3: if (n != 0) begin
        for (int i = 0; i < W; i++) r[i] = a[(i + n) % W];
        c = r[W-1];
      end
      4: begin
        for (int i = 0; i < W - 1; i++) r[i] = a[i + 1];
        r[W-1] = cin;
        c = a[0];
      end
      default: ;
    endcase
    return {c, r};
  endfunction

  typedef struct packed {
    logic [W-1:0]  res;
    logic          cout;
    logic [TW-1:0] tag;
    logic          ill;
  } exp_t;

  exp_t sb[$];

  task automatic idle_inputs();
    in_valid = 1'b0; in_a = '0; in_op = '0; in_amt = '0; in_cin = 1'b0; in_tag = '0;
    flush = 1'b0;
  endtask

  // One op with out_ready high; checks latency and the spec-given values
  task automatic run_one(input string name, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [AW-1:0] amt, input logic cin, input logic [TW-1:0] tag,
                         input logic [W-1:0] e_res, input logic e_cout, input logic e_ill);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_amt = amt; in_cin = cin; in_tag = tag;
    out_ready = 1'b1;
    #1 chk({name, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_lat1_vld"}, out_valid, 0);
    @(negedge clk);
    chk({name, "_vld"}, out_valid, 1);
    chk({name, "_res"}, out_result, e_res);
    chk({name, "_cout"}, out_cout, e_cout);
    chk({name, "_tag"}, out_tag, tag);
    chk({name, "_ill"}, out_illegal, e_ill);
  endtask

  initial begin
    int acc;
    int got_tags[$];
    int emerged;
    logic sent;
    logic stall_prev;
    logic [W-1:0] prev_res;
    logic [TW-1:0] prev_tag;
    logic prev_cout;
    exp_t e;
    logic [W:0] m;

    idle_inputs();
    out_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_cout", out_cout, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_illegal", out_illegal, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_one("lsl1",   3'd0, 32'h80000001, 8'd1,   1'b0, 4'd1, 32'h00000002, 1'b1, 1'b0);
    run_one("lsl0",   3'd0, 32'h80000001, 8'd0,   1'b1, 4'd2, 32'h80000001, 1'b1, 1'b0);
    run_one("lsr32",  3'd1, 32'h80000000, 8'd32,  1'b0, 4'd3, 32'h00000000, 1'b1, 1'b0);
    run_one("lsr33",  3'd1, 32'h80000000, 8'd33,  1'b0, 4'd4, 32'h00000000, 1'b0, 1'b0);
    run_one("lsl32",  3'd0, 32'h00000001, 8'd32,  1'b0, 4'd5, 32'h00000000, 1'b1, 1'b0);
    run_one("asr4",   3'd2, 32'hF0000000, 8'd4,   1'b0, 4'd6, 32'hFF000000, 1'b0, 1'b0);
    run_one("asr200", 3'd2, 32'hF0000000, 8'd200, 1'b0, 4'd7, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_one("ror1",   3'd3, 32'h00000001, 8'd1,   1'b0, 4'd8, 32'h80000000, 1'b1, 1'b0);
    run_one("ror64",  3'd3, 32'h00000001, 8'd64,  1'b1, 4'd9, 32'h00000001, 1'b0, 1'b0);
    run_one("ror33",  3'd3, 32'h00000001, 8'd33,  1'b0, 4'd10, 32'h80000000, 1'b1, 1'b0);
    run_one("rrx",    3'd4, 32'h00000003, 8'd77,  1'b1, 4'd11, 32'h80000001, 1'b1, 1'b0);
    run_one("ill6",   3'd6, 32'h00001234, 8'd5,   1'b1, 4'd12, 32'h00001234, 1'b1, 1'b1);

    // Stall: tags 1,2,3 back-to-back with out_ready low
    @(negedge clk);
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_op = 3'd0; in_amt = '0; in_a = W'(acc + 1); in_tag = TW'(acc + 1);
      #1 sent = in_ready;
      @(posedge clk);
      if (sent) acc++;
    end
    #1 in_valid = 1'b0;
    chk("stall_accepts", acc, 2);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_hold_vld", out_valid, 1);
      chk("stall_hold_tag", out_tag, 1);
      chk("stall_in_ready", in_ready, 0);
    end
    // Release: tag 3 issued, all three drain in order
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 32'd3; in_tag = 4'd3;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (out_valid) got_tags.push_back(int'(out_tag));
      sent = in_valid && in_ready;
      @(posedge clk);
      #1 if (sent) in_valid = 1'b0;
    end
    chk("drain_count", got_tags.size(), 3);
    for (int k = 0; k < 3; k++)
      chk("drain_order", (k < got_tags.size()) ? got_tags[k] : -1, k + 1);

    // Flush with two ops in flight
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_op = 3'd1; in_amt = 8'd1; in_a = 32'hFF; in_tag = TW'(c + 4);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
    @(negedge clk);
    chk("pre_flush_vld", out_valid, 1);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("flush_in_ready", in_ready, 0);
    @(posedge clk);
    #1 begin flush = 1'b0; in_valid = 1'b0; end
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    emerged = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid) emerged++;
    end
    chk("flush_nothing", emerged, 0);

    // Async reset with a result sitting on the outputs
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'd0; in_amt = 8'd4; in_a = 32'h1; in_tag = 4'd9;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_vld", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_vld", out_valid, 0);
    chk("async_rst_tag", out_tag, 0);
    chk("async_rst_res", out_result, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the reference model
    stall_prev = 1'b0;
    prev_res = '0; prev_tag = '0; prev_cout = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_a      = $urandom;
      in_op     = 3'($urandom_range(0, 7));
      in_cin    = 1'($urandom_range(0, 1));
      in_tag    = TW'($urandom_range(0, 15));
      case ($urandom_range(0, 7))
        0: in_amt = 8'd0;
        1: in_amt = 8'd1;
        2: in_amt = 8'(W - 1);
        3: in_amt = 8'(W);
        4: in_amt = 8'(W + 1);
        5: in_amt = 8'(2 * W);
        default: in_amt = 8'($urandom_range(0, 255));
      endcase
      #1;
      if (stall_prev) begin
        chk("hold_vld", out_valid, 1);
        chk("hold_res", out_result, prev_res);
        chk("hold_cout", out_cout, prev_cout);
        chk("hold_tag", out_tag, prev_tag);
      end
      stall_prev = out_valid && !out_ready;
      prev_res = out_result; prev_tag = out_tag; prev_cout = out_cout;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("rnd_unexpected_out", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("rnd_res", out_result, e.res);
          chk("rnd_cout", out_cout, e.cout);
          chk("rnd_tag", out_tag, e.tag);
          chk("rnd_ill", out_illegal, e.ill);
        end
      end
      if (in_valid && in_ready) begin
        m = ref_shift(in_a, int'(in_op), int'(in_amt), in_cin);
        e.res = m[W-1:0]; e.cout = m[W]; e.tag = in_tag; e.ill = (in_op > 3'd4);
        sb.push_back(e);
      end
      if (sb.size() > 2) chk("rnd_occupancy", sb.size(), 2);
    end

    // Drain with a bounded wait
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid && sb.size() != 0) begin
        e = sb.pop_front();
        chk("drain_res", out_result, e.res);
        chk("drain_tag", out_tag, e.tag);
      end
      @(negedge clk);
    end
    chk("drain_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
